// File: rtl/cached_fetcher.sv
// cached_fetcher: instruction fetcher with a direct-mapped cache in front of program memory
module cached_fetcher #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 32,
   parameter int CACHE_ENTRIES = 8,
   parameter int COUNTER_BITS = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic [2:0] core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS:0] current_pc,
   input  logic flush,
   output logic mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0] fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic fetch_hit,
   output logic [COUNTER_BITS-1:0] hit_count,
   output logic [COUNTER_BITS-1:0] miss_count
);
   localparam int A = PROGRAM_MEM_ADDR_BITS;
   localparam int D = PROGRAM_MEM_DATA_BITS;
   localparam int C = COUNTER_BITS;
   localparam int IDX = $clog2(CACHE_ENTRIES);
   localparam int TW = A - IDX;
   localparam logic [C-1:0] ONE = 1;

   typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;

   state_t state_q, state_d;
   logic [CACHE_ENTRIES-1:0] valid_q, valid_d;
   logic [TW-1:0] tag_q [CACHE_ENTRIES];
   logic [D-1:0] data_q [CACHE_ENTRIES];
   logic mem_valid_q, mem_valid_d;
   logic [A-1:0] addr_q, addr_d;
   logic [D-1:0] instr_q, instr_d;
   logic hit_q, hit_d, drop_q, drop_d, fill_en, hit;
   logic [C-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic [A-1:0] pc;
   logic [IDX-1:0] idx, ridx;
   logic unused_pc_msb;

   assign pc = current_pc[A-1:0];
   assign unused_pc_msb = current_pc[A];
   assign idx = pc[IDX-1:0];
   assign ridx = addr_q[IDX-1:0];
   assign hit = valid_q[idx] && (tag_q[idx] == pc[A-1:IDX]) && !flush;

   always_comb begin
      state_d = state_q;
      valid_d = flush ? '0 : valid_q;
      mem_valid_d = mem_valid_q;
      addr_d = addr_q;
      instr_d = instr_q;
      hit_d = hit_q;
      drop_d = drop_q;
      hit_cnt_d = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      fill_en = 1'b0;
      case (state_q)
         IDLE: if (core_state == 3'b001) begin
            if (hit) begin
               instr_d = data_q[idx];
               hit_d = 1'b1;
               hit_cnt_d = &hit_cnt_q ? hit_cnt_q : hit_cnt_q + ONE;
               state_d = FETCHED;
            end else begin
               mem_valid_d = 1'b1;
               addr_d = pc;
               hit_d = 1'b0;
               miss_cnt_d = &miss_cnt_q ? miss_cnt_q : miss_cnt_q + ONE;
               state_d = FETCHING;
            end
         end
         FETCHING: begin
            drop_d = drop_q | flush;
            if (mem_read_ready) begin
               instr_d = mem_read_data;
               mem_valid_d = 1'b0;
               drop_d = 1'b0;
               state_d = FETCHED;
               // a flush seen at any point of this miss makes the returned line stale
               fill_en = !drop_q && !flush && !reset;
               if (fill_en) valid_d[ridx] = 1'b1;
            end
         end
         FETCHED: state_d = (core_state == 3'b010) ? IDLE : FETCHED;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         mem_valid_q <= 1'b0;
         addr_q <= '0;
         instr_q <= '0;
         hit_q <= 1'b0;
         drop_q <= 1'b0;
         hit_cnt_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         mem_valid_q <= mem_valid_d;
         addr_q <= addr_d;
         instr_q <= instr_d;
         hit_q <= hit_d;
         drop_q <= drop_d;
         hit_cnt_q <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[ridx] <= addr_q[A-1:IDX];
         data_q[ridx] <= mem_read_data;
      end
   end

   assign fetcher_state = state_q;
   assign mem_read_valid = mem_valid_q;
   assign mem_read_address = addr_q;
   assign instruction = instr_q;
   assign fetch_hit = hit_q;
   assign hit_count = hit_cnt_q;
   assign miss_count = miss_cnt_q;
endmodule

// File: doc/cached_fetcher.md
Name: cached_fetcher

Overview:
Parametrised next-generation per-core instruction fetcher. It adds a direct-mapped instruction cache in front of program memory.
- Hits deliver the instruction in one cycle with no memory traffic.
- Misses use the program-memory valid/ready handshake and fill the cache.
- Supports a synchronous flush (e.g. after program reload) and exposes saturating hit/miss counters for performance monitoring.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, program memory address width.
- PROGRAM_MEM_DATA_BITS, 32, instruction width.
- CACHE_ENTRIES, 8, number of cache lines (one instruction per line); power of two, 2..2^PROGRAM_MEM_ADDR_BITS.
- COUNTER_BITS, 16, width of the hit/miss counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- core_state  input  3  core execution state; 3'b001 = FETCH, 3'b010 = DECODE.
- current_pc  input  PROGRAM_MEM_ADDR_BITS+1  program counter; only the low PROGRAM_MEM_ADDR_BITS bits are used.
- flush  input  1  invalidate all cache lines.
- mem_read_valid  output  1  program memory read request.
- mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address.
- mem_read_ready  input  1  read data valid this cycle.
- mem_read_data  input  PROGRAM_MEM_DATA_BITS  read data.
- fetcher_state  output  3  IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010.
- instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction; stable while in FETCHED.
- fetch_hit  output  1  1 if the current instruction came from the cache.
- hit_count  output  COUNTER_BITS  saturating hit counter.
- miss_count  output  COUNTER_BITS  saturating miss counter.

Behaviour:
- Address split:
  - IDX = log2(CACHE_ENTRIES).
  - index = pc[IDX-1:0].
  - tag = pc[PROGRAM_MEM_ADDR_BITS-1:IDX], width PROGRAM_MEM_ADDR_BITS-IDX.
- Storage: per line a valid bit, tag and data. Only the valid bits are reset; tag and data arrays are not reset.
- Reset, applied at any time including mid-fetch:
  - fetcher_state = IDLE.
  - mem_read_valid = 0, mem_read_address = 0.
  - instruction = 0, fetch_hit = 0.
  - Counters = 0, all valid bits = 0, drop_fill = 0.
  - An in-flight memory response after reset is ignored.
- IDLE, when core_state == FETCH:
  - Hit (valid[index] && tag match && !flush):
    - instruction <= data[index], fetch_hit <= 1.
    - hit_count increments; state goes to FETCHED.
    - Latency is 1 cycle; mem_read_valid stays 0.
  - Otherwise (miss):
    - mem_read_valid <= 1, mem_read_address <= pc low bits.
    - fetch_hit <= 0, miss_count increments; state goes to FETCHING.
  - A flush asserted in the same cycle forces a miss.
- FETCHING:
  - mem_read_valid and mem_read_address are held until mem_read_ready.
  - On the ready cycle:
    - instruction <= mem_read_data, mem_read_valid <= 0, state goes to FETCHED.
    - The line at the request index is filled (valid = 1, tag, data) unless drop_fill is set or flush is high that cycle.
  - flush in FETCHING sets drop_fill; drop_fill clears on leaving FETCHING.
  - The fetched instruction is still delivered to the core even when the fill is dropped.
- FETCHED: returns to IDLE when core_state == DECODE; otherwise holds.
- flush, any state: all valid bits clear on the next edge. Flush has priority over a same-cycle fill. Counters are unaffected.
- Counters saturate at all-ones and never wrap; each fetch increments exactly one of them.
- Index aliasing: different tags at the same index evict each other; this is a miss, not an error.
- core_state values other than FETCH or DECODE: no action.

Test Plan:
- Cold fetch:
  - Stimulus: reset, pc = 0x05, FETCH; memory answers 0xDEADBEEF after 3 cycles.
  - Response: mem_read_valid = 1 with address 0x05 until ready; instruction = 0xDEADBEEF; fetch_hit = 0; miss_count = 1; FETCHED until DECODE, then IDLE.
- Warm hit:
  - Stimulus: refetch pc = 0x05.
  - Response: FETCHED one cycle after FETCH; mem_read_valid never 1; instruction = 0xDEADBEEF; fetch_hit = 1; hit_count = 1.
- Alias eviction (CACHE_ENTRIES = 8):
  - Stimulus: fetch 0x05 (data A), then 0x0D (data B), then 0x05.
  - Response: three misses; the third requests address 0x05 and returns A.
- Flush during FETCHING:
  - Stimulus: flush pulsed while a miss on 0x20 is outstanding; then refetch 0x20.
  - Response: the first fetch still delivers the data; the refetch misses (miss_count = 2).
- Flush with FETCH in IDLE:
  - Stimulus: line 0x05 cached; flush and FETCH in the same cycle.
  - Response: treated as a miss (memory request issued); hit_count unchanged.
- Reset mid-fetch, then saturation:
  - Stimulus: assert reset while in FETCHING, with memory ready arriving the next cycle. Separately, with COUNTER_BITS = 2, perform 5 hits.
  - Response:
    - Reset case: IDLE, no cache fill, instruction = 0.
    - Saturation case: hit_count = 3.
